// File: rtl/watch_time_counter_pkg.sv
// Shared watch definitions: mode encodings driven by watch_fsm and the
// base-60 modulus used by the counters and the display.
package watch_time_counter_pkg;

  typedef enum logic [2:0] {
    S_STOPWATCH_HIDE_STOPPED = 3'b000,
    S_SET_H                  = 3'b001,
    S_SET_M                  = 3'b010,
    S_STOPWATCH_SHOW_STOPPED = 3'b011,
    S_STOPWATCH_SHOW_RUNNING = 3'b100,
    S_STOPWATCH_RESET        = 3'b101,
    S_STOPWATCH_HIDE_RUNNING = 3'b110
  } watch_state_e;

  // Seconds and minutes both count modulo sixty.
  localparam int MOD_60 = 32'd60;

endpackage

// File: rtl/watch_time_counter_mod_counter.sv
// Registered modulo-MOD counter with clear and enable; carry flags the
// enabled step that wraps back to zero, so counters chain by carry.
module mod_counter #(
  parameter int MOD = 32'd60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  output logic [5:0] value,
  output logic       carry
);

  localparam logic [5:0] LAST = 6'(MOD - 32'd1);

  // Count register: reset/clear to zero, step on enable, wrap at MOD-1.
  // The >= compare keeps the value legal even if it were ever disturbed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= 6'd0;
    end else if (clr) begin
      value <= 6'd0;
    end else if (en) begin
      if (value >= LAST) begin
        value <= 6'd0;
      end else begin
        value <= value + 6'd1;
      end
    end else begin
      value <= value;
    end
  end

  assign carry = en && (value == LAST);

endmodule

// File: rtl/watch_time_counter.sv
// Time-of-day and stopwatch counters for the watch. A rising edge of the
// 1 Hz seconds_clk is turned into a one-cycle tick; the current mode decides
// which counter chains see the tick and whether the set button is honoured.
module watch_time_counter
  import watch_time_counter_pkg::*;
#(
  parameter int HOUR_MOD    = 32'd24,
  parameter int SW_HOUR_MOD = 32'd24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seconds_clk,
  input  logic [2:0] state,
  input  logic       inc,
  output logic [5:0] current_s,
  output logic [5:0] current_m,
  output logic [5:0] current_h,
  output logic [5:0] stopwatch_s,
  output logic [5:0] stopwatch_m,
  output logic [5:0] stopwatch_h
);

  logic seconds_prev;
  logic tick;
  logic time_run, set_h, set_m, sw_run, sw_clr;
  logic tod_s_carry, tod_m_carry, tod_h_carry_unused;
  logic sw_s_carry, sw_m_carry, sw_h_carry_unused;
  logic tod_m_en, tod_h_en;

  // Seconds_clk history; resets high so a level already high at release
  // is not mistaken for a fresh edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seconds_prev <= 1'b1;
    end else begin
      seconds_prev <= seconds_clk;
    end
  end

  assign tick = seconds_clk && !seconds_prev;

  // Mode decode: which chains run, which are being set, stopwatch clear.
  // Undefined mode 3'b111 falls to the default and freezes everything.
  always_comb begin
    time_run = 1'b0;
    set_h    = 1'b0;
    set_m    = 1'b0;
    sw_run   = 1'b0;
    sw_clr   = 1'b0;
    case (state)
      S_SET_H: set_h = 1'b1;
      S_SET_M: set_m = 1'b1;
      S_STOPWATCH_RESET: begin
        time_run = 1'b1;
        sw_clr   = 1'b1;
      end
      S_STOPWATCH_SHOW_RUNNING, S_STOPWATCH_HIDE_RUNNING: begin
        time_run = 1'b1;
        sw_run   = 1'b1;
      end
      S_STOPWATCH_HIDE_STOPPED, S_STOPWATCH_SHOW_STOPPED: time_run = 1'b1;
      default: time_run = 1'b0;
    endcase
  end

  // A minute wrap while setting minutes must not reach the hours, so the
  // carry path into hours is gated by the running condition.
  assign tod_m_en = (time_run && tod_s_carry) || (set_m && inc);
  assign tod_h_en = (time_run && tod_m_carry) || (set_h && inc);

  mod_counter #(.MOD(MOD_60)) u_tod_s (
    .clk(clk), .rst_n(rst_n), .en(tick && time_run), .clr(set_h || set_m),
    .value(current_s), .carry(tod_s_carry)
  );

  mod_counter #(.MOD(MOD_60)) u_tod_m (
    .clk(clk), .rst_n(rst_n), .en(tod_m_en), .clr(1'b0),
    .value(current_m), .carry(tod_m_carry)
  );

  mod_counter #(.MOD(HOUR_MOD)) u_tod_h (
    .clk(clk), .rst_n(rst_n), .en(tod_h_en), .clr(1'b0),
    .value(current_h), .carry(tod_h_carry_unused)
  );

  mod_counter #(.MOD(MOD_60)) u_sw_s (
    .clk(clk), .rst_n(rst_n), .en(tick && sw_run), .clr(sw_clr),
    .value(stopwatch_s), .carry(sw_s_carry)
  );

  mod_counter #(.MOD(MOD_60)) u_sw_m (
    .clk(clk), .rst_n(rst_n), .en(sw_s_carry), .clr(sw_clr),
    .value(stopwatch_m), .carry(sw_m_carry)
  );

  mod_counter #(.MOD(SW_HOUR_MOD)) u_sw_h (
    .clk(clk), .rst_n(rst_n), .en(sw_m_carry), .clr(sw_clr),
    .value(stopwatch_h), .carry(sw_h_carry_unused)
  );

endmodule

// File: tb/tb_watch_time_counter.sv
// Scoreboard bench for watch_time_counter: a behavioural model predicts all
// six outputs for every driven cycle, plus directed checks at milestones.
module tb_watch_time_counter;
  import watch_time_counter_pkg::*;

  localparam int HM  = 24;
  localparam int SHM = 24;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       seconds_clk = 1'b0;
  logic [2:0] state = 3'b000;
  logic       inc = 1'b0;
  logic [5:0] current_s, current_m, current_h;
  logic [5:0] stopwatch_s, stopwatch_m, stopwatch_h;

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  int  mh = 0, mm = 0, ms = 0, wh = 0, wm = 0, ws = 0;
  bit  mprev = 1'b1;
  logic [35:0] exp_q[$];

  watch_time_counter #(.HOUR_MOD(HM), .SW_HOUR_MOD(SHM)) dut (
    .clk(clk), .rst_n(rst_n), .seconds_clk(seconds_clk), .state(state),
    .inc(inc),
    .current_s(current_s), .current_m(current_m), .current_h(current_h),
    .stopwatch_s(stopwatch_s), .stopwatch_m(stopwatch_m),
    .stopwatch_h(stopwatch_h)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [35:0] got,
                          input logic [35:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got h%0d m%0d s%0d sw %0d:%0d:%0d, expected h%0d m%0d s%0d sw %0d:%0d:%0d",
                  tag, got[35:30], got[29:24], got[23:18], got[17:12], got[11:6], got[5:0],
                  exp[35:30], exp[29:24], exp[23:18], exp[17:12], exp[11:6], exp[5:0]);
  endtask

  function automatic logic [35:0] dut_vec();
    return {current_h, current_m, current_s, stopwatch_h, stopwatch_m, stopwatch_s};
  endfunction

  function automatic logic [35:0] model_vec();
    return {6'(mh), 6'(mm), 6'(ms), 6'(wh), 6'(wm), 6'(ws)};
  endfunction

  // Behavioural prediction of one clock edge.
  task automatic model_step(input logic r, input logic sc, input logic [2:0] st,
                            input logic i);
    bit t;
    if (!r) begin
      mh = 0; mm = 0; ms = 0; wh = 0; wm = 0; ws = 0; mprev = 1'b1;
    end else begin
      t = sc && !mprev;
      mprev = sc;
      if (st == S_SET_H) begin
        ms = 0;
        if (i) mh = (mh + 1) % HM;
      end else if (st == S_SET_M) begin
        ms = 0;
        if (i) mm = (mm + 1) % 60;
      end else if (st != 3'b111 && t) begin
        int tot;
        tot = ((mh * 60 + mm) * 60 + ms + 1) % (HM * 3600);
        mh = tot / 3600; mm = (tot / 60) % 60; ms = tot % 60;
      end
      if (st == S_STOPWATCH_RESET) begin
        wh = 0; wm = 0; ws = 0;
      end else if ((st == S_STOPWATCH_SHOW_RUNNING || st == S_STOPWATCH_HIDE_RUNNING) && t) begin
        int tot;
        tot = ((wh * 60 + wm) * 60 + ws + 1) % (SHM * 3600);
        wh = tot / 3600; wm = (tot / 60) % 60; ws = tot % 60;
      end
    end
  endtask

  // One cycle: drive, predict, push; after the edge pop and compare.
  task automatic cyc(input logic r, input logic sc, input logic [2:0] st,
                     input logic i);
    logic [35:0] e;
    rst_n = r; seconds_clk = sc; state = st; inc = i;
    model_step(r, sc, st, i);
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("sb", dut_vec(), e);
  endtask

  task automatic pulses(input logic [2:0] st, input int n);
    repeat (n) begin
      cyc(1'b1, 1'b1, st, 1'b0);
      cyc(1'b1, 1'b0, st, 1'b0);
    end
  endtask

  task automatic incs(input logic [2:0] st, input int n);
    repeat (n) cyc(1'b1, 1'b0, st, 1'b1);
  endtask

  initial begin
    int t0, dt;
    // reset state
    cyc(1'b0, 1'b0, 3'b000, 1'b0);
    cyc(1'b0, 1'b0, 3'b000, 1'b0);
    check_eq("reset", dut_vec(), 36'd0);

    // build 23:59:58 then roll over
    incs(S_SET_H, 23);
    incs(S_SET_M, 59);
    pulses(S_STOPWATCH_HIDE_STOPPED, 58);
    check_eq("t_235958", dut_vec(), {6'd23, 6'd59, 6'd58, 18'd0});
    pulses(S_STOPWATCH_HIDE_STOPPED, 1);
    check_eq("t_235959", dut_vec(), {6'd23, 6'd59, 6'd59, 18'd0});
    pulses(S_STOPWATCH_HIDE_STOPPED, 1);
    check_eq("t_wrap", dut_vec(), 36'd0);

    // inc ignored outside set modes
    incs(S_STOPWATCH_HIDE_STOPPED, 3);
    check_eq("inc_ignored", dut_vec(), 36'd0);

    // hour set wraps 23 -> 0, ticks ignored in set mode
    incs(S_SET_H, 23);
    check_eq("seth_23", dut_vec(), {6'd23, 30'd0});
    incs(S_SET_H, 1);
    check_eq("seth_wrap", dut_vec(), 36'd0);
    pulses(S_SET_H, 3);
    check_eq("seth_noticks", dut_vec(), 36'd0);

    // stopwatch running, then stopped
    pulses(S_STOPWATCH_SHOW_RUNNING, 59);
    check_eq("sw_59", {18'd0, stopwatch_h, stopwatch_m, stopwatch_s}, {30'd0, 6'd59});
    pulses(S_STOPWATCH_SHOW_RUNNING, 1);
    check_eq("sw_100", {18'd0, stopwatch_h, stopwatch_m, stopwatch_s}, {24'd0, 6'd1, 6'd0});
    pulses(S_STOPWATCH_SHOW_STOPPED, 5);
    check_eq("sw_hold", {18'd0, stopwatch_h, stopwatch_m, stopwatch_s}, {24'd0, 6'd1, 6'd0});

    // hidden running stopwatch alongside time, then clear
    cyc(1'b1, 1'b0, S_STOPWATCH_RESET, 1'b0);
    check_eq("sw_clr0", {18'd0, stopwatch_h, stopwatch_m, stopwatch_s}, 36'd0);
    pulses(S_STOPWATCH_HIDE_RUNNING, 10);
    t0 = (mh * 60 + mm) * 60 + ms;
    pulses(S_STOPWATCH_HIDE_RUNNING, 4);
    check_eq("sw_14", {18'd0, stopwatch_h, stopwatch_m, stopwatch_s}, {30'd0, 6'd14});
    dt = (int'(current_h) * 60 + int'(current_m)) * 60 + int'(current_s);
    check_eq("tod_plus4", 36'(dt), 36'(t0 + 4));
    cyc(1'b1, 1'b0, S_STOPWATCH_RESET, 1'b0);
    check_eq("sw_clr", {18'd0, stopwatch_h, stopwatch_m, stopwatch_s}, 36'd0);

    // undefined mode freezes everything
    pulses(3'b111, 3);
    incs(3'b111, 2);

    // minute set: simultaneous inc and tick at 59
    while (mm != 59) cyc(1'b1, 1'b0, S_SET_M, 1'b1);
    check_eq("setm_59", {current_h, current_m, current_s, 18'd0}, {6'd0, 6'd59, 6'd0, 18'd0});
    cyc(1'b1, 1'b1, S_SET_M, 1'b1);
    check_eq("setm_wrap", dut_vec(), 36'd0);
    cyc(1'b1, 1'b0, S_SET_M, 1'b0);

    // 12:34:56, then reset with seconds_clk held high
    while (mh != 12) cyc(1'b1, 1'b0, S_SET_H, 1'b1);
    while (mm != 34) cyc(1'b1, 1'b0, S_SET_M, 1'b1);
    while (ms != 55) pulses(S_STOPWATCH_HIDE_STOPPED, 1);
    cyc(1'b1, 1'b1, S_STOPWATCH_HIDE_STOPPED, 1'b0);
    check_eq("t_123456", dut_vec(), {6'd12, 6'd34, 6'd56, 18'd0});
    cyc(1'b0, 1'b1, S_STOPWATCH_HIDE_STOPPED, 1'b1);
    check_eq("rst_mid", dut_vec(), 36'd0);
    repeat (3) cyc(1'b1, 1'b1, S_STOPWATCH_SHOW_RUNNING, 1'b0);
    check_eq("rst_notick", dut_vec(), 36'd0);
    cyc(1'b1, 1'b0, S_STOPWATCH_SHOW_RUNNING, 1'b0);
    cyc(1'b1, 1'b1, S_STOPWATCH_SHOW_RUNNING, 1'b0);
    check_eq("rst_resume", dut_vec(), {12'd0, 6'd1, 12'd0, 6'd1});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/watch_time_counter.md
WATCH_TIME_COUNTER -- requirements
Module: watch_time_counter

Interface
REQ-001 SHALL have parameter HOUR_MOD, default 24, meaning the time-of-day hour modulus (hours 0..HOUR_MOD-1).
REQ-002 SHALL have parameter SW_HOUR_MOD, default 24, meaning the stopwatch hour modulus.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port seconds_clk, input, 1 bit: 1 Hz square wave from the divider, synchronous to clk.
REQ-006 SHALL have port state, input, 3 bits: mode from watch_fsm, using the shared encodings.
REQ-007 SHALL have port inc, input, 1 bit: debounced single-cycle increment pulse from the set button.
REQ-008 SHALL have ports current_s, current_m and current_h, outputs, 6 bits each: time-of-day binary values, registered.
REQ-009 SHALL have ports stopwatch_s, stopwatch_m and stopwatch_h, outputs, 6 bits each: stopwatch binary values, registered.

Function
REQ-010 SHALL derive tick = seconds_clk high at the current edge AND low at the previous edge, using one history register.
REQ-011 SHALL make every output a register, updated on the same clk edge at which tick is detected (one-cycle latency from sampled rising edge).
REQ-012 SHALL advance time by 1 s on tick in all states except S_SET_H, S_SET_M and 3'b111.
REQ-013 SHALL wrap time seconds 59->0 with carry to minutes, minutes 59->0 with carry to hours, and hours HOUR_MOD-1->0 (23:59:59 -> 00:00:00).
REQ-014 SHALL, in S_SET_H, increment current_h by 1 on inc (23->0), leave minutes unchanged, and ignore tick.
REQ-015 SHALL, in S_SET_M, increment current_m by 1 on inc (59->0), with no carry into hours, and ignore tick.
REQ-016 SHALL force current_s to 0 every cycle while in S_SET_H or S_SET_M.
REQ-017 SHALL ignore inc in every state other than S_SET_H and S_SET_M.
REQ-018 SHALL advance the stopwatch by 1 s on tick only in S_STOPWATCH_SHOW_RUNNING or S_STOPWATCH_HIDE_RUNNING, with the same 59/59/SW_HOUR_MOD-1 wrap chain.
REQ-019 SHALL clear all stopwatch outputs to 0 on every cycle in S_STOPWATCH_RESET, with no tick applied.
REQ-020 SHALL hold stopwatch values in all other states, including S_SET_H and S_SET_M.
REQ-021 SHALL, on simultaneous tick and inc in a set state, apply only inc; a stopwatch in a running state still counts that tick.
REQ-022 SHALL hold all counters in undefined state 3'b111.
REQ-023 SHALL never drive any output outside its legal range (s, m <= 59; h <= modulus-1).

Reset
REQ-024 SHALL, while rst_n is low at a clk edge, load all six outputs with 0, regardless of state, inc or tick.
REQ-025 SHALL reset the seconds_clk history register to 1, so that a high seconds_clk at reset release produces no tick.
REQ-026 SHALL let rst_n asserted mid-count override any concurrent tick or inc, with counting resuming from 00:00:00 on the first qualifying tick after release.

Structure
REQ-027 SHALL place the state encodings (S_STOPWATCH_HIDE_STOPPED=000, S_SET_H=001, S_SET_M=010, S_STOPWATCH_SHOW_STOPPED=011, S_STOPWATCH_SHOW_RUNNING=100, S_STOPWATCH_RESET=101, S_STOPWATCH_HIDE_RUNNING=110) and the constant 60 in the shared watch package, also used by watch_fsm and Seg7Display.
REQ-028 SHALL implement the counting through one sub-module, mod_counter (parameter MOD; ports clk, rst_n, en, clr; outputs 6-bit value and carry = en AND value==MOD-1), instantiated six times and chained by carry.

Verification
REQ-029 SHALL cover: state=000, time 23:59:58, two seconds_clk rising edges -> 23:59:59, then 00:00:00; stopwatch unchanged.
REQ-030 SHALL cover: state=001, current_h=23, one inc pulse -> current_h=0, current_m unchanged, current_s=0; 3 ticks -> no change.
REQ-031 SHALL cover: state=100, stopwatch 00:00:59, one tick -> 00:01:00; state=011, 5 ticks -> stays 00:01:00.
REQ-032 SHALL cover: state=110, stopwatch at 00:00:10, 4 ticks -> 00:00:14 while time also advances 4 s; then state=101 for 1 cycle -> stopwatch 00:00:00.
REQ-033 SHALL cover: state=010, inc and tick on the same edge, current_m=59 -> current_m=0, current_h unchanged, current_s=0.
REQ-034 SHALL cover: rst_n low for 1 cycle with seconds_clk held high, time 12:34:56 -> all outputs 0, and no tick until the next low-to-high transition of seconds_clk.
